// File: rtl/aoi_pkg.sv
// Shared types and golden model for the AOI cell self-test sequencer.
package aoi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int N_VEC = 16;

    function automatic logic aoi_ref(input logic [3:0] vec);
        return ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    endfunction

endpackage

// File: rtl/aoi_settle_timer.sv
// Settle down-counter: load to SETTLE_CYCLES-1, decrement, zero flag.
module aoi_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [3:0] INIT = 4'(SETTLE_CYCLES - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= INIT;
        end else if (dec && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/aoi_sweep_ctrl.sv
// Built-in checker sweeping all 16 AOI input vectors against a golden model.
// Optional AOI_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module aoi_sweep_ctrl
    import aoi_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       fail_vld,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] LAST_VEC = 4'(N_VEC - 1);

    state_t     state, state_n;
    logic [3:0] vec, vec_n;
    logic [4:0] err_n;
    logic       fvld_n;
    logic [3:0] fvec_n;
    logic       pass_n;
    logic       load;
    logic       dec;
    logic       zero;
    logic       mism;

    aoi_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(load),
        .dec (dec),
        .zero(zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vec      <= 4'd0;
            err_cnt  <= 5'd0;
            fail_vld <= 1'b0;
            fail_vec <= 4'd0;
            pass     <= 1'b0;
        end else begin
            state    <= state_n;
            vec      <= vec_n;
            err_cnt  <= err_n;
            fail_vld <= fvld_n;
            fail_vec <= fvec_n;
            pass     <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        vec_n   = vec;
        err_n   = err_cnt;
        fvld_n  = fail_vld;
        fvec_n  = fail_vec;
        pass_n  = pass;
        load    = 1'b0;
        dec     = 1'b0;
        mism    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    vec_n   = 4'd0;
                    err_n   = 5'd0;
                    fvld_n  = 1'b0;
                    fvec_n  = 4'd0;
                    pass_n  = 1'b0;
                    load    = 1'b1;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                dec = 1'b1;
                if (zero) state_n = SAMPLE;
            end
            SAMPLE: begin
                mism = (y_in != aoi_ref(vec));
                if (mism) begin
                    err_n = err_cnt + 5'd1;
                    if (!fail_vld) begin
                        fvld_n = 1'b1;
                        fvec_n = vec;
                    end
                end
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
                if (mism || vec == LAST_VEC) begin
`else
                if (vec == LAST_VEC) begin
`endif
                    // pass reflects the count including this final sample
                    pass_n  = (err_n == 5'd0);
                    state_n = DONE;
                end else begin
                    vec_n   = vec + 4'd1;
                    load    = 1'b1;
                    state_n = SETTLE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign {a, b, c, d} = vec;
    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// Directed bench for aoi_sweep_ctrl with a programmable faulty AOI model.
module tb_aoi_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       a, b, c, d;
    logic       y_in;
    logic       busy, done, pass, fail_vld;
    logic [4:0] err_cnt;
    logic [3:0] fail_vec;

    int errors = 0;
    int checks = 0;

    // 0 golden, 1 stuck-at-0, 2 inverted, 3 wrong only on vector 13
    int mode = 0;
    logic [3:0] v;
    logic [3:0] v22;

    always #5 clk = ~clk;

    aoi_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .y_in    (y_in),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .fail_vld(fail_vld),
        .fail_vec(fail_vec)
    );

    assign v = {a, b, c, d};

    always_comb begin
        logic g;
        g = ~((v[3] & v[2]) | (v[1] & v[0]));
        y_in = g;
        case (mode)
            1: y_in = 1'b0;
            2: y_in = ~g;
            3: y_in = (v == 4'd13) ? ~g : g;
            default: y_in = g;
        endcase
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen at the next posedge (cycle 0).
    task automatic sweep(input int rp, output int dcyc,
                         output int ndone, output int nbusy);
        dcyc = -1;
        ndone = 0;
        nbusy = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            start = (k == rp);
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = k;
            end
            if (busy) nbusy++;
            if (k == 22) v22 = v;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int dc, nd, nb;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec", v, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", {pass, err_cnt, fail_vld, fail_vec}, 0);

        // golden sweep
        mode = 0;
        sweep(0, dc, nd, nb);
        check("gold_done_cyc", dc, 49);
        check("gold_ndone", nd, 1);
        check("gold_busy", nb, 48);
        check("gold_vec7", v22, 7);
        check("gold_pass", pass, 1);
        check("gold_err", err_cnt, 0);
        check("gold_fvld", fail_vld, 0);
        check("gold_hold_vec", v, 15);

        // stuck-at-0
        mode = 1;
        sweep(0, dc, nd, nb);
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
        check("s0_done_cyc", dc, 4);
        check("s0_err", err_cnt, 1);
`else
        check("s0_done_cyc", dc, 49);
        check("s0_err", err_cnt, 9);
`endif
        check("s0_fvec", fail_vec, 0);
        check("s0_fvld", fail_vld, 1);
        check("s0_pass", pass, 0);

        // inverted
        mode = 2;
        sweep(0, dc, nd, nb);
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
        check("inv_done_cyc", dc, 4);
        check("inv_err", err_cnt, 1);
        check("inv_hold_vec", v, 0);
`else
        check("inv_done_cyc", dc, 49);
        check("inv_err", err_cnt, 16);
`endif
        check("inv_fvec", fail_vec, 0);
        check("inv_pass", pass, 0);

        // single fault on 1101
        mode = 3;
        sweep(0, dc, nd, nb);
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
        check("sf_done_cyc", dc, 43);
`else
        check("sf_done_cyc", dc, 49);
`endif
        check("sf_err", err_cnt, 1);
        check("sf_fvec", fail_vec, 13);
        check("sf_fvld", fail_vld, 1);
        check("sf_pass", pass, 0);

        // reset during vector 7 settle, with errors already recorded
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (22) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_vec", v, 7);
        rst = 1'b1;
        #1;
        check("mid_rst_outs",
              {v, busy, done, pass, err_cnt, fail_vld, fail_vec}, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("mid_no_done", nd, 0);
        mode = 0;
        sweep(0, dc, nd, nb);
        check("post_rst_cyc", dc, 49);
        check("post_rst_pass", pass, 1);

        // start re-pulsed while on vector 3
        mode = 3;
        sweep(10, dc, nd, nb);
        check("rp_done_cyc", dc, 49);
        check("rp_ndone", nd, 1);
        check("rp_err", err_cnt, 1);
        check("rp_fvec", fail_vec, 13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
